// File: rtl/gin_mcast_bus_buffered.sv
// GIN multicast bus with a one-entry holding stage and per-slave delivery tracking.
// Ports: clk/rst, master stream (tag/master_valid/master_data/master_ready),
//        per-slave slave_valid/slave_ready with shared slave_data,
//        ID scan chain (set_id/ID_scan_in/ID_scan_out), busy and drop status.
module gin_mcast_bus_buffered #(
    parameter int NUMS_SLAVE = 4,
    parameter int ID_SIZE    = 4,
    parameter int DATA_SIZE  = 16,
    parameter bit BCAST_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_SIZE-1:0]    tag,
    input  logic                  master_valid,
    input  logic [DATA_SIZE-1:0]  master_data,
    output logic                  master_ready,
    input  logic [NUMS_SLAVE-1:0] slave_ready,
    output logic [NUMS_SLAVE-1:0] slave_valid,
    output logic [DATA_SIZE-1:0]  slave_data,
    input  logic                  set_id,
    input  logic [ID_SIZE-1:0]    ID_scan_in,
    output logic [ID_SIZE-1:0]    ID_scan_out,
    output logic                  busy,
    output logic                  drop
);

    typedef enum logic {
        IDLE,
        DELIVER
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ID_SIZE-1:0]    ids [NUMS_SLAVE];
    logic [NUMS_SLAVE-1:0] match;
    logic [NUMS_SLAVE-1:0] pending;
    logic [NUMS_SLAVE-1:0] done;
    logic                  bcast;
    logic                  hit;
    logic                  last;
    logic                  accept;

    // Tag decode against the scanned-in slave IDs.
    always_comb begin
        bcast = BCAST_EN && (tag == {ID_SIZE{1'b1}});
        for (int i = 0; i < NUMS_SLAVE; i++) begin
            match[i] = (ids[i] == tag) || bcast;
        end
    end

    // The held beat retires when every still-pending slave handshakes now.
    assign done    = pending & slave_ready;
    assign last    = ~|(pending & ~done);
    assign hit     = |match;
    assign accept  = master_valid && master_ready;

    assign master_ready = !rst && !set_id &&
                          ((state == IDLE) || ((state == DELIVER) && last));

    assign ID_scan_out = ids[NUMS_SLAVE-1];

    // ID scan chain, shifting regardless of delivery state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUMS_SLAVE; i++) begin
                ids[i] <= '0;
            end
        end else if (set_id) begin
            ids[0] <= ID_scan_in;
            for (int i = 1; i < NUMS_SLAVE; i++) begin
                ids[i] <= ids[i-1];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept && hit) begin
                    state_nxt = DELIVER;
                end
            end
            DELIVER: begin
                if (last) begin
                    state_nxt = (accept && hit) ? DELIVER : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Holding stage. An accept only happens when the held beat is retiring,
    // so loading the new mask never loses an outstanding delivery; with no
    // accept, pending & ~done is already zero once the beat is last.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            slave_data <= '0;
            drop       <= 1'b0;
        end else begin
            drop <= accept && !hit;
            if (accept) begin
                pending <= match;
            end else begin
                pending <= pending & ~done;
            end
            if (accept && hit) begin
                slave_data <= master_data;
            end
        end
    end

    // Outputs.
    always_comb begin
        slave_valid = pending;
        busy        = (state == DELIVER);
    end

endmodule

// File: tb/tb_gin_mcast_bus_buffered.sv
// Randomized and directed bench for gin_mcast_bus_buffered.
// Outputs are compared each cycle against a per-slave delivery model.
module tb_gin_mcast_bus_buffered;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  tag;
    logic        master_valid;
    logic [15:0] master_data;
    logic        master_ready;
    logic [3:0]  slave_ready;
    logic [3:0]  slave_valid;
    logic [15:0] slave_data;
    logic        set_id;
    logic [3:0]  ID_scan_in;
    logic [3:0]  ID_scan_out;
    logic        busy;
    logic        drop;

    int checks = 0;
    int errors = 0;

    // Reference model: IDs, which slaves still owe a handshake, held data.
    logic [3:0]  m_id [4];
    bit          m_owe [4];
    logic [15:0] m_data;
    bit          m_drop;

    gin_mcast_bus_buffered #(
        .NUMS_SLAVE(4),
        .ID_SIZE(4),
        .DATA_SIZE(16),
        .BCAST_EN(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tag(tag),
        .master_valid(master_valid),
        .master_data(master_data),
        .master_ready(master_ready),
        .slave_ready(slave_ready),
        .slave_valid(slave_valid),
        .slave_data(slave_data),
        .set_id(set_id),
        .ID_scan_in(ID_scan_in),
        .ID_scan_out(ID_scan_out),
        .busy(busy),
        .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] owe_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_owe[i];
        return v;
    endfunction

    function automatic bit any_owe();
        bit a = 0;
        for (int i = 0; i < 4; i++) a |= m_owe[i];
        return a;
    endfunction

    // One clock cycle: drive, check outputs, advance model, cross the edge.
    task automatic step(input bit r, input bit sid, input logic [3:0] sin,
                        input bit mv, input logic [3:0] tg,
                        input logic [15:0] dt, input logic [3:0] rdy);
        bit all_ok;
        bit exp_rdy;
        bit acc;
        int ntgt;
        bit tgt [4];
        @(negedge clk);
        rst = r; set_id = sid; ID_scan_in = sin;
        master_valid = mv; tag = tg; master_data = dt; slave_ready = rdy;
        #1;
        all_ok = 1;
        for (int i = 0; i < 4; i++)
            if (m_owe[i] && !rdy[i]) all_ok = 0;
        exp_rdy = !r && !sid && all_ok;
        check("master_ready", master_ready, exp_rdy);
        check("slave_valid", slave_valid, owe_vec());
        check("slave_data", slave_data, m_data);
        check("busy", busy, any_owe());
        check("drop", drop, m_drop);
        check("scan_out", ID_scan_out, m_id[3]);
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_id[i] = 0;
                m_owe[i] = 0;
            end
            m_data = 0;
            m_drop = 0;
        end else begin
            acc = mv && exp_rdy;
            ntgt = 0;
            for (int i = 0; i < 4; i++) begin
                tgt[i] = (m_id[i] == tg) || (tg == 4'hF);
                if (tgt[i]) ntgt++;
            end
            for (int i = 0; i < 4; i++)
                m_owe[i] = acc ? tgt[i] : (m_owe[i] && !rdy[i]);
            if (acc && ntgt > 0) m_data = dt;
            m_drop = acc && (ntgt == 0);
            if (sid) begin
                for (int i = 3; i > 0; i--) m_id[i] = m_id[i-1];
                m_id[0] = sin;
            end
        end
        @(posedge clk);
    endtask

    task automatic scan(input logic [3:0] v);
        step(0, 1, v, 0, 0, 0, 4'hF);
    endtask

    task automatic load_ids(input logic [3:0] a3, input logic [3:0] a2,
                            input logic [3:0] a1, input logic [3:0] a0);
        scan(a3); scan(a2); scan(a1); scan(a0);
    endtask

    task automatic beat(input logic [3:0] tg, input logic [15:0] dt,
                        input logic [3:0] rdy);
        step(0, 0, 0, 1, tg, dt, rdy);
    endtask

    task automatic idle(input logic [3:0] rdy);
        step(0, 0, 0, 0, 0, 0, rdy);
    endtask

    initial begin
        rst = 1; set_id = 0; ID_scan_in = 0;
        master_valid = 0; tag = 0; master_data = 0; slave_ready = 0;
        for (int i = 0; i < 4; i++) begin
            m_id[i] = 0;
            m_owe[i] = 0;
        end
        m_data = 0;
        m_drop = 0;
        repeat (2) @(posedge clk);

        // Reset state, then scan configuration.
        step(1, 0, 0, 1, 0, 16'h1234, 0);
        load_ids(3, 2, 1, 0);
        #1 check("scan_cfg_out", ID_scan_out, 4'd3);
        scan(9);
        #1 check("scan_extra_out", ID_scan_out, 4'd2);
        load_ids(3, 2, 1, 0);

        // Unicast.
        beat(2, 16'h00A5, 4'hF);
        #1 check("unicast_valid", slave_valid, 4'b0100);
        check("unicast_data", slave_data, 16'h00A5);
        idle(4'hF);

        // Multicast with staggered ready: ids 1,1,0,1.
        load_ids(1, 0, 1, 1);
        beat(1, 16'hBEEF, 4'h0);
        #1 check("mcast_valid", slave_valid, 4'b1011);
        step(0, 0, 0, 1, 1, 16'h0001, 4'b0001);
        step(0, 0, 0, 1, 1, 16'h0002, 4'b0000);
        step(0, 0, 0, 1, 1, 16'h0003, 4'b1000);
        step(0, 0, 0, 1, 1, 16'h0004, 4'b0000);
        #1 check("mcast_mid", slave_valid, 4'b0010);
        check("mcast_hold", slave_data, 16'hBEEF);
        step(0, 0, 0, 0, 1, 16'h0005, 4'b0010);
        #1 check("mcast_end", slave_valid, 4'b0000);

        // Broadcast, then a no-match drop.
        beat(4'hF, 16'h0F0F, 4'hF);
        #1 check("bcast_valid", slave_valid, 4'b1111);
        beat(7, 16'h0707, 4'hF);
        #1 check("drop_pulse", drop, 1'b1);
        idle(4'hF);
        #1 check("drop_clear", drop, 1'b0);

        // Back-to-back streaming.
        load_ids(3, 2, 1, 0);
        for (int i = 0; i < 8; i++)
            beat(4'(i % 4), 16'(16'h100 + i), 4'hF);
        idle(4'hF);

        // Reset mid-delivery: pending 0110.
        load_ids(0, 5, 5, 0);
        beat(5, 16'h5555, 4'h0);
        #1 check("rst_pre_valid", slave_valid, 4'b0110);
        idle(4'h0);
        step(1, 0, 0, 0, 0, 0, 4'h0);
        #1 check("rst_valid", slave_valid, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_ids", ID_scan_out, 4'd0);
        idle(4'h0);

        // Randomized traffic.
        load_ids(3, 2, 1, 0);
        for (int n = 0; n < 3000; n++) begin
            bit r;
            bit sid;
            logic [3:0] tg;
            logic [3:0] rdy;
            r = ($urandom_range(99) == 0);
            sid = ($urandom_range(15) == 0);
            case ($urandom_range(3))
                0: tg = m_id[$urandom_range(3)];
                1: tg = 4'hF;
                default: tg = 4'($urandom_range(15));
            endcase
            rdy = ($urandom_range(3) == 0) ? 4'hF : 4'($urandom);
            step(r, sid, 4'($urandom_range(14)), 1'($urandom),
                 tg, 16'($urandom), rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
